// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment message display:
// active-low glyphs, the code-to-message table, code constants and the
// digit-scan state type.
package display_pkg;

  // Glyphs, active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLY_A     = 7'h08;
  localparam logic [6:0] GLY_C     = 7'h46;
  localparam logic [6:0] GLY_E     = 7'h06;
  localparam logic [6:0] GLY_F     = 7'h0E;
  localparam logic [6:0] GLY_G     = 7'h42;
  localparam logic [6:0] GLY_H     = 7'h09;
  localparam logic [6:0] GLY_I     = 7'h79;
  localparam logic [6:0] GLY_L     = 7'h47;
  // There is no true M on seven segments; a, c and e together read as one.
  localparam logic [6:0] GLY_M     = 7'h6A;
  localparam logic [6:0] GLY_N     = 7'h48;
  localparam logic [6:0] GLY_O     = 7'h40;
  localparam logic [6:0] GLY_P     = 7'h0C;
  localparam logic [6:0] GLY_R     = 7'h2F;
  localparam logic [6:0] GLY_T     = 7'h07;
  localparam logic [6:0] GLY_U     = 7'h41;
  localparam logic [6:0] GLY_DASH  = 7'h3F;
  localparam logic [6:0] GLY_BLANK = 7'h7F;

  // Message codes with special meaning
  localparam logic [3:0] COD_OCIO = 4'h0;
  localparam logic [3:0] COD_ERRO = 4'hF;

  // Messages packed {D3,D2,D1,D0}, D3 is the leftmost digit
  localparam logic [27:0] MSG_DASH = {GLY_DASH, GLY_DASH, GLY_DASH, GLY_DASH};
  localparam logic [27:0] MSG_CAFE = {GLY_C, GLY_A, GLY_F, GLY_E};
  localparam logic [27:0] MSG_LEIT = {GLY_L, GLY_E, GLY_I, GLY_T};
  localparam logic [27:0] MSG_CHOC = {GLY_C, GLY_H, GLY_O, GLY_C};
  localparam logic [27:0] MSG_AGUA = {GLY_A, GLY_G, GLY_U, GLY_A};
  localparam logic [27:0] MSG_PAGO = {GLY_P, GLY_A, GLY_G, GLY_O};
  localparam logic [27:0] MSG_TROC = {GLY_T, GLY_R, GLY_O, GLY_C};
  localparam logic [27:0] MSG_PRON = {GLY_P, GLY_R, GLY_O, GLY_N};
  localparam logic [27:0] MSG_FIM  = {GLY_F, GLY_I, GLY_M, GLY_BLANK};
  localparam logic [27:0] MSG_ERRO = {GLY_E, GLY_R, GLY_R, GLY_O};

  // Code-indexed message table; the concatenation lists entry 15 first
  localparam logic [15:0][27:0] MSG_TABLE = {
    MSG_ERRO,                                         // F
    MSG_DASH, MSG_DASH, MSG_DASH,                     // E D C
    MSG_DASH, MSG_DASH, MSG_DASH,                     // B A 9
    MSG_FIM,  MSG_PRON, MSG_TROC, MSG_PAGO,           // 8 7 6 5
    MSG_AGUA, MSG_CHOC, MSG_LEIT, MSG_CAFE,           // 4 3 2 1
    MSG_DASH                                          // 0
  };

  // Digit-scan states; the encoding equals the digit index
  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } digit_e;

  // Scan order runs left to right: D3, D2, D1, D0, then back to D3
  function automatic digit_e next_digit(input digit_e d);
    case (d)
      D3:      return D2;
      D2:      return D1;
      D1:      return D0;
      default: return D3;
    endcase
  endfunction

  // Active-low one-hot anode enable for a digit
  function automatic logic [3:0] anode_of(input digit_e d);
    case (d)
      D3:      return 4'b0111;
      D2:      return 4'b1011;
      D1:      return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_decoder_glyph_rom.sv
// Combinational lookup of the glyph shown on one digit of a message.
module glyph_rom
  import display_pkg::*;
(
  input  logic [3:0] code,
  input  logic [1:0] digit,
  output logic [6:0] glyph
);

  logic [27:0] entry;

  // Select the message for the code, then the slice for the digit
  always_comb begin
    entry = MSG_TABLE[code];
    glyph = GLY_BLANK;
    case (digit)
      2'd3:    glyph = entry[27:21];
      2'd2:    glyph = entry[20:14];
      2'd1:    glyph = entry[13:7];
      default: glyph = entry[6:0];
    endcase
  end

endmodule

// File: rtl/display_scan_decoder.sv
// Drives the 4-digit multiplexed 7-segment display from the 4-bit message
// code: captures the code, scans the digits on a prescaled tick and blinks
// the error message.
module display_scan_decoder
  import display_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] bitsDisplay,
  output logic [6:0] segmentos,
  output logic [3:0] anodos,
  output logic       erro
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [3:0]    code_q, code_d;
  logic          erro_q, erro_d;
  logic [PW-1:0] presc_q, presc_d;
  digit_e        digit_q, digit_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [3:0]    anodos_q, anodos_d;
  logic [6:0]    segmentos_q, segmentos_d;

  logic          scan_tick;
  logic          restart;
  logic [6:0]    rom_glyph;

  // The glyph is looked up with the incoming code so that a code change
  // landing on a scan tick is shown straight away.
  glyph_rom u_glyph_rom (
    .code  (bitsDisplay),
    .digit (digit_q),
    .glyph (rom_glyph)
  );

  // Next-state logic for prescaler, digit scan, blink and output registers.
  // digit_q names the digit that is lit on the next scan tick.
  always_comb begin
    scan_tick   = (presc_q == PRESC_LAST);
    restart     = (bitsDisplay != code_q);

    code_d      = bitsDisplay;
    erro_d      = (bitsDisplay == COD_ERRO);
    presc_d     = scan_tick ? '0 : presc_q + PW'(1);

    digit_d     = digit_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    anodos_d    = anodos_q;
    segmentos_d = segmentos_q;

    // A new message always restarts visible; only the error message blinks
    if (restart || (code_q != COD_ERRO)) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (scan_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    // The scan keeps advancing while dark so the phase is never lost
    if (scan_tick) begin
      digit_d = next_digit(digit_q);
      if (restart || blink_on_q) begin
        anodos_d    = anode_of(digit_q);
        segmentos_d = rom_glyph;
      end else begin
        anodos_d    = 4'hF;
        segmentos_d = GLY_BLANK;
      end
    end
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code_q      <= COD_OCIO;
      erro_q      <= 1'b0;
      presc_q     <= '0;
      digit_q     <= D3;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      anodos_q    <= 4'hF;
      segmentos_q <= GLY_BLANK;
    end else begin
      code_q      <= code_d;
      erro_q      <= erro_d;
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      anodos_q    <= anodos_d;
      segmentos_q <= segmentos_d;
    end
  end

  assign segmentos = segmentos_q;
  assign anodos    = anodos_q;
  assign erro      = erro_q;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder with a scoreboard of expected
// (anodos, segmentos) pushed before each scan tick and popped after it.
module tb_display_scan_decoder;

  localparam int SD = 4;
  localparam int BT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] code;
  logic [6:0] seg;
  logic [3:0] an;
  logic       er;

  always #5 clk = ~clk;

  display_scan_decoder #(
    .SCAN_DIV    (SD),
    .BLINK_TICKS (BT)
  ) dut (
    .clock       (clk),
    .reset       (rst),
    .bitsDisplay (code),
    .segmentos   (seg),
    .anodos      (an),
    .erro        (er)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [10:0] sb[$];

  // Reference model state
  int         m_pc;      // clocks since the last scan tick
  int         m_pos;     // next digit to light, 0 = leftmost
  int         m_fticks;  // scan ticks since the error message (re)started
  logic [3:0] m_code;
  logic [3:0] held_an;
  logic [6:0] held_seg;

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  // Messages this bench exercises: 0, 1, 9..F
  function automatic logic [6:0] exp_glyph(input logic [3:0] c, input int p);
    logic [27:0] s;
    case (c)
      4'h1:    s = {7'h46, 7'h08, 7'h0E, 7'h06};
      4'hF:    s = {7'h06, 7'h2F, 7'h2F, 7'h40};
      default: s = {4{7'h3F}};
    endcase
    return s[27 - 7*p -: 7];
  endfunction

  task automatic model_reset();
    m_pc     = 0;
    m_pos    = 0;
    m_fticks = 0;
    m_code   = 4'h0;
    held_an  = 4'hF;
    held_seg = 7'h7F;
    sb.delete();
  endtask

  // One clock: predict, let the edge happen, compare 1 time unit later
  task automatic clock_once();
    logic       tick;
    logic       chg;
    logic       lit;
    logic [3:0] ea;
    logic [6:0] es;
    logic [10:0] got;
    tick = (m_pc == SD - 1);
    chg  = (code != m_code);
    if (tick) begin
      lit = chg || (code != 4'hF) || (((m_fticks / BT) % 2) == 0);
      ea  = lit ? ~(4'b1000 >> m_pos) : 4'hF;
      es  = lit ? exp_glyph(code, m_pos) : 7'h7F;
      sb.push_back({ea, es});
      m_pos = (m_pos + 1) % 4;
    end
    if (chg) m_fticks = 0;
    else if (tick && code == 4'hF) m_fticks++;
    m_code = code;
    m_pc   = (m_pc + 1) % SD;
    @(posedge clk);
    #1;
    check("erro", {10'b0, er}, {10'b0, (m_code == 4'hF)});
    if (tick) begin
      got = sb.pop_front();
      check("tick_out", {an, seg}, got);
      held_an  = got[10:7];
      held_seg = got[6:0];
      $display("tick: code=%h anodos=%b segmentos=%h erro=%b", m_code, an, seg, er);
    end else begin
      check("hold_out", {an, seg}, {held_an, held_seg});
    end
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    code = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_an",   {7'b0, an},  11'h00F);
    check("rst_seg",  {4'b0, seg}, 11'h07F);
    check("rst_erro", {10'b0, er}, 11'h000);
    rst = 1'b0;
    model_reset();

    // Idle message, then CAFE scanned through more than one full cycle
    repeat (3 * SD) clock_once();
    code = 4'h1;
    repeat (5 * SD) clock_once();

    // ERRO blinks: two ticks lit, two ticks dark
    code = 4'hF;
    repeat (9 * SD) clock_once();

    // Stop right after a dark tick, then leave the error while dark
    for (int i = 0; i < 8 * SD && held_an !== 4'hF; i++) clock_once();
    check("reach_dark", {7'b0, an}, 11'h00F);
    code = 4'h1;
    repeat (3 * SD) clock_once();

    // Undefined codes show dashes and never blink
    for (int c = 9; c <= 14; c++) begin
      code = 4'(c);
      repeat (3 * SD) clock_once();
    end

    // Back-to-back changes on consecutive clocks; last code is CAFE
    for (int c = 9; c <= 17; c++) begin
      code = 4'(c);
      clock_once();
    end
    repeat (5 * SD) clock_once();

    // Asynchronous reset between clock edges
    code = 4'hF;
    repeat (3) clock_once();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_an",   {7'b0, an},  11'h00F);
    check("async_rst_seg",  {4'b0, seg}, 11'h07F);
    check("async_rst_erro", {10'b0, er}, 11'h000);
    code = 4'h0;
    repeat (2) @(negedge clk);
    check("held_rst_an", {7'b0, an}, 11'h00F);
    rst = 1'b0;
    model_reset();
    repeat (3 * SD) clock_once();

    check("sb_empty", 11'(sb.size()), 11'h000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
